// File: rtl/reel_spin_controller.sv
// Three-reel slot machine motion sequencer: fast spin, staggered settle onto
// symbol boundaries, then a one-cycle result strobe carrying each stop symbol.
module reel_spin_controller #(
    parameter int         REEL_HEIGHT    = 480,
    parameter int         SYMBOL_PITCH   = 120,
    parameter int         FAST_STEP      = 8,
    parameter int         SLOW_STEP      = 2,
    parameter int         SPIN_FRAMES    = 120,
    parameter int         STAGGER_FRAMES = 30,
    parameter bit         RAND_EN        = 1'b1,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    output logic [9:0] reel_offset0,
    output logic [9:0] reel_offset1,
    output logic [9:0] reel_offset2,
    output logic [2:0] reel_spinning,
    output logic [1:0] stop_idx0,
    output logic [1:0] stop_idx1,
    output logic [1:0] stop_idx2,
    output logic       busy,
    output logic       result_valid
);

    localparam int NUM_REELS   = 3;
    localparam int NUM_SYMBOLS = REEL_HEIGHT / SYMBOL_PITCH;

    typedef enum logic [1:0] {TOP_IDLE, TOP_SPIN, TOP_DONE} top_state_e;
    typedef enum logic [1:0] {REEL_STOPPED, REEL_FAST, REEL_SETTLE} reel_state_e;

    top_state_e  top_q, top_d;
    reel_state_e reel_q [NUM_REELS];
    reel_state_e reel_d [NUM_REELS];
    logic [9:0]  offset_q [NUM_REELS];
    logic [9:0]  offset_d [NUM_REELS];
    logic [1:0]  idx_q [NUM_REELS];
    logic [1:0]  idx_d [NUM_REELS];
    logic [9:0]  frame_cnt_q, frame_cnt_d;
    logic [9:0]  spin_len_q, spin_len_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        start_prev_q, start_prev_d;
    logic        start_rise;

    // Advance an offset by step pixels, wrapping modulo REEL_HEIGHT.
    function automatic logic [9:0] wrap_add(input logic [9:0] off, input int step);
        logic [10:0] sum;
        sum = {1'b0, off} + 11'(step);
        if (sum >= 11'(REEL_HEIGHT))
            sum = sum - 11'(REEL_HEIGHT);
        return sum[9:0];
    endfunction

    assign start_rise = start & ~start_prev_q;

    always_comb begin : next_state
        logic       settling;
        logic       all_stopped;
        logic [9:0] new_off;
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        top_d        = top_q;
        reel_d       = reel_q;
        offset_d     = offset_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        spin_len_d   = spin_len_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        start_prev_d = start;
        settling     = 1'b0;
        all_stopped  = 1'b1;
        new_off      = '0;

        case (top_q)
            TOP_IDLE: begin
                if (start_rise) begin
                    frame_cnt_d = '0;
                    spin_len_d  = 10'(SPIN_FRAMES) + (RAND_EN ? {4'd0, lfsr_q[5:0]} : 10'd0);
                    for (int k = 0; k < NUM_REELS; k++)
                        reel_d[k] = REEL_FAST;
                    top_d = TOP_SPIN;
                end
            end
            TOP_SPIN: begin
                if (frame_tick) begin
                    for (int k = 0; k < NUM_REELS; k++) begin
                        settling = (reel_q[k] == REEL_SETTLE) ||
                                   ((reel_q[k] == REEL_FAST) &&
                                    (frame_cnt_q >= spin_len_q + 10'(k * STAGGER_FRAMES)));
                        if (settling) begin
                            // An aligned reel still moves once before it can stop.
                            new_off     = wrap_add(offset_q[k], SLOW_STEP);
                            offset_d[k] = new_off;
                            reel_d[k]   = REEL_SETTLE;
                            for (int s = 0; s < NUM_SYMBOLS; s++) begin
                                if (new_off == 10'(s * SYMBOL_PITCH)) begin
                                    reel_d[k] = REEL_STOPPED;
                                    idx_d[k]  = 2'(s);
                                end
                            end
                        end else if (reel_q[k] == REEL_FAST) begin
                            offset_d[k] = wrap_add(offset_q[k], FAST_STEP);
                        end
                        if (reel_d[k] != REEL_STOPPED)
                            all_stopped = 1'b0;
                    end
                    frame_cnt_d = frame_cnt_q + 10'd1;
                    if (all_stopped)
                        top_d = TOP_DONE;
                end
            end
            TOP_DONE: top_d = TOP_IDLE;
            default:  top_d = TOP_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge CLK) begin
        if (reset) begin
            top_q        <= TOP_IDLE;
            frame_cnt_q  <= '0;
            spin_len_q   <= '0;
            lfsr_q       <= LFSR_SEED;
            // NOTE: previous-start resets high so a button held through reset
            // does not count as a press.
            start_prev_q <= 1'b1;
            for (int k = 0; k < NUM_REELS; k++) begin
                reel_q[k]   <= REEL_STOPPED;
                offset_q[k] <= '0;
                idx_q[k]    <= '0;
            end
        end else begin
            top_q        <= top_d;
            frame_cnt_q  <= frame_cnt_d;
            spin_len_q   <= spin_len_d;
            lfsr_q       <= lfsr_d;
            start_prev_q <= start_prev_d;
            reel_q       <= reel_d;
            offset_q     <= offset_d;
            idx_q        <= idx_d;
        end
    end

    assign reel_offset0  = offset_q[0];
    assign reel_offset1  = offset_q[1];
    assign reel_offset2  = offset_q[2];
    assign stop_idx0     = idx_q[0];
    assign stop_idx1     = idx_q[1];
    assign stop_idx2     = idx_q[2];
    assign reel_spinning = {reel_q[2] != REEL_STOPPED,
                            reel_q[1] != REEL_STOPPED,
                            reel_q[0] != REEL_STOPPED};
    assign busy          = (top_q != TOP_IDLE);
    assign result_valid  = (top_q == TOP_DONE);

endmodule
